conv_window_gen: RTL and testbench
==================================

Name: conv_window_gen

Overview:
- Read-side controller for the cascaded 3x3 line-buffer pair feeding the Conv2D3x3 core.
- Configures both line buffers: pulses their depth-load input with the image width.
- Consumes vertically aligned column beats (top/mid/bottom rows) and tracks row and column position.
- Assembles a registered 3x3 window and emits it only where the window lies fully inside the image (valid convolution, no padding).

Parameters:
- WIDTH, 8, bits per pixel.
- MAX_WIDTH, 512, maximum image width in pixels. Must equal the line buffers' MAX_DEPTH.
- MAX_HEIGHT, 512, maximum image height in rows.

Ports:
- i_clk  in  1  clock.
- i_reset_n  in  1  reset, asynchronous assert, active-low.
- i_cfg_valid  in  1  one-cycle config strobe.
- i_img_width  in  $clog2(MAX_WIDTH)+1  image width W.
- i_img_height  in  $clog2(MAX_HEIGHT)+1  image height H.
- o_cfg_err  out  1  sticky config error; cleared by the next accepted config.
- o_busy  out  1  high when state != IDLE.
- o_lb_load_depth  out  1  depth-load pulse to both line buffers.
- o_lb_depth  out  $clog2(MAX_WIDTH)+1  depth value for the line buffers (= W).
- i_col_valid  in  1  column beat valid; no backpressure.
- i_col_top  in  WIDTH  pixel at row r-2.
- i_col_mid  in  WIDTH  pixel at row r-1.
- i_col_bot  in  WIDTH  pixel at row r (current raster pixel).
- o_win_valid  out  1  window valid, one-cycle pulse per window.
- o_win  out  9*WIDTH  window. Element (row rr, column cc) is at [(rr*3+cc)*WIDTH +: WIDTH]; rr=0 is top, cc=0 is leftmost/oldest.
- o_win_row  out  $clog2(MAX_HEIGHT)  row index of the bottom window row.
- o_win_col  out  $clog2(MAX_WIDTH)  column index of the rightmost window column.
- o_frame_done  out  1  one-cycle pulse after the last beat of a frame.

Behaviour:
- Reset (async, i_reset_n=0):
  - State = IDLE; row and column counters = 0; window registers = 0.
  - All outputs 0, including o_lb_depth and o_cfg_err.
- Every output is registered.
- State IDLE:
  - i_col_valid is ignored.
  - On i_cfg_valid, the config is checked. W<3, W>MAX_WIDTH, H<3 or H>MAX_HEIGHT is invalid.
  - Invalid config: o_cfg_err <= 1 and the state stays IDLE.
  - Valid config: latch W and H, o_cfg_err <= 0, go to LOAD.
- State LOAD (exactly one cycle):
  - o_lb_load_depth = 1 and o_lb_depth = W in this cycle.
  - Counters clear; then go to RUN.
  - o_lb_depth holds W until the next accepted config.
- State RUN, per beat with i_col_valid=1:
  - The window shifts left: columns cc1 and cc2 move to cc0 and cc1; {top, mid, bot} load into cc2.
  - Column counter: c = c+1, wrapping to 0 at W-1. Row counter: r increments on column wrap.
  - If r>=2 and c>=2 for the beat being consumed: o_win_valid=1 on the next cycle, with o_win_row=r and o_win_col=c. Latency is 1 cycle, beat to window.
  - Windows straddling a row wrap (c<2) never assert valid. Stale columns from the previous row therefore never leak out.
- Gaps in RUN: a cycle with i_col_valid=0 holds all registers. o_win_valid = 0 that cycle; o_win holds its last value.
- Frame end: the beat at r=H-1, c=W-1 produces the final window. o_frame_done pulses in the same cycle as that window's o_win_valid. Counters return to 0 and the state stays RUN, so back-to-back frames need no reconfiguration.
- i_cfg_valid during RUN:
  - The current frame is aborted with no o_frame_done; that cycle's beat is dropped.
  - The config is then validated as in IDLE. Valid: go to LOAD. Invalid: set o_cfg_err and go to IDLE.
- i_cfg_valid during LOAD is ignored.
- Async reset mid-frame: the effect is immediate. All state is lost, and a new config is required.
- Window count per frame = (W-2)*(H-2).

Test Plan:
- Config W=4, H=3; stream 12 beats with pixel value = row*16+col, with top/mid/bot supplied from rows r-2/r-1/r.
  - o_lb_load_depth pulses once with o_lb_depth=4.
  - Exactly 2 windows are produced.
  - First window: o_win_row=2, o_win_col=2, element (0,0)=0x00, element (2,2)=0x22.
  - o_frame_done coincides with the second window (col=3).
- Config W=2, H=5 -> o_cfg_err=1, o_busy=0, no load pulse. Then W=3, H=3 -> o_cfg_err=0 and exactly 1 window.
- W=5, H=4 with i_col_valid deasserted for 3 cycles mid-row 2 -> window contents and coordinates are identical to the gap-free run; 6 windows total; o_win_valid low during the gap.
- Two back-to-back frames at W=4, H=4 with no reconfig -> 4 windows per frame, o_frame_done pulses twice, and the second frame's first window is at (2,2).
- i_cfg_valid (W=6, H=3) at row 1 of a W=4 frame -> no o_frame_done, one load pulse with depth 6, then 4 windows for the new frame.
- i_reset_n dropped asynchronously mid-window-burst -> all outputs go to 0 immediately, o_busy=0, and beats are ignored until reconfiguration.

Source files
------------

// File: rtl/conv_window_gen.sv
// Read-side controller for the cascaded 3x3 line-buffer pair: configures buffer depth,
// tracks raster position of incoming column beats and emits valid-only 3x3 windows.
//
// state  | meaning
// IDLE   | waiting for an accepted config; column beats ignored
// LOAD   | one cycle: depth-load pulse to both line buffers, counters cleared
// RUN    | consuming column beats, shifting window, emitting in-image windows
module conv_window_gen #(
    parameter int WIDTH      = 8,
    parameter int MAX_WIDTH  = 512,
    parameter int MAX_HEIGHT = 512
) (
    input  logic                            i_clk,
    input  logic                            i_reset_n,
    input  logic                            i_cfg_valid,
    input  logic [$clog2(MAX_WIDTH):0]      i_img_width,
    input  logic [$clog2(MAX_HEIGHT):0]     i_img_height,
    output logic                            o_cfg_err,
    output logic                            o_busy,
    output logic                            o_lb_load_depth,
    output logic [$clog2(MAX_WIDTH):0]      o_lb_depth,
    input  logic                            i_col_valid,
    input  logic [WIDTH-1:0]                i_col_top,
    input  logic [WIDTH-1:0]                i_col_mid,
    input  logic [WIDTH-1:0]                i_col_bot,
    output logic                            o_win_valid,
    output logic [9*WIDTH-1:0]              o_win,
    output logic [$clog2(MAX_HEIGHT)-1:0]   o_win_row,
    output logic [$clog2(MAX_WIDTH)-1:0]    o_win_col,
    output logic                            o_frame_done
);

    localparam int DW = $clog2(MAX_WIDTH) + 1;
    localparam int HW = $clog2(MAX_HEIGHT) + 1;
    localparam int CW = $clog2(MAX_WIDTH);
    localparam int RW = $clog2(MAX_HEIGHT);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    logic [1:0]    state, state_d;
    logic [DW-1:0] img_w;
    logic [HW-1:0] img_h;
    logic [CW-1:0] col_cnt;
    logic [RW-1:0] row_cnt;
    logic          cfg_ok, beat, col_last, row_last, win_inside;

    assign cfg_ok = (i_img_width  >= DW'(3)) && (i_img_width  <= DW'(MAX_WIDTH)) &&
                    (i_img_height >= HW'(3)) && (i_img_height <= HW'(MAX_HEIGHT));

    // A config strobe in RUN aborts the frame, so that cycle's beat is dropped.
    assign beat       = (state == S_RUN) && i_col_valid && !i_cfg_valid;
    assign col_last   = (DW'(col_cnt) == img_w - DW'(1));
    assign row_last   = (HW'(row_cnt) == img_h - HW'(1));
    assign win_inside = (row_cnt >= RW'(2)) && (col_cnt >= CW'(2));

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  if (i_cfg_valid && cfg_ok) state_d = S_LOAD;
            S_LOAD:  state_d = S_RUN;
            S_RUN:   if (i_cfg_valid) state_d = cfg_ok ? S_LOAD : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state           <= S_IDLE;
            img_w           <= '0;
            img_h           <= '0;
            col_cnt         <= '0;
            row_cnt         <= '0;
            o_cfg_err       <= 1'b0;
            o_busy          <= 1'b0;
            o_lb_load_depth <= 1'b0;
            o_lb_depth      <= '0;
            o_win_valid     <= 1'b0;
            o_win           <= '0;
            o_win_row       <= '0;
            o_win_col       <= '0;
            o_frame_done    <= 1'b0;
        end else begin
            state           <= state_d;
            o_busy          <= (state_d != S_IDLE);
            o_lb_load_depth <= (state_d == S_LOAD);
            o_win_valid     <= 1'b0;
            o_frame_done    <= 1'b0;

            if (i_cfg_valid && state != S_LOAD) begin
                o_cfg_err <= !cfg_ok;
                if (cfg_ok) begin
                    img_w      <= i_img_width;
                    img_h      <= i_img_height;
                    o_lb_depth <= i_img_width;
                end
            end

            if (state == S_LOAD) begin
                col_cnt <= '0;
                row_cnt <= '0;
            end

            if (beat) begin
                for (int rr = 0; rr < 3; rr++) begin
                    o_win[(rr*3)*WIDTH +: WIDTH]   <= o_win[(rr*3+1)*WIDTH +: WIDTH];
                    o_win[(rr*3+1)*WIDTH +: WIDTH] <= o_win[(rr*3+2)*WIDTH +: WIDTH];
                end
                o_win[2*WIDTH +: WIDTH] <= i_col_top;
                o_win[5*WIDTH +: WIDTH] <= i_col_mid;
                o_win[8*WIDTH +: WIDTH] <= i_col_bot;

                // Window columns from the previous row sit at c<2, so gating on c>=2 hides them.
                o_win_valid  <= win_inside;
                o_frame_done <= col_last && row_last;
                if (win_inside) begin
                    o_win_row <= row_cnt;
                    o_win_col <= col_cnt;
                end

                if (col_last) begin
                    col_cnt <= '0;
                    row_cnt <= row_last ? '0 : row_cnt + RW'(1);
                end else begin
                    col_cnt <= col_cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_window_gen.sv
// Randomized bench for conv_window_gen: frames are drawn into a pixel array and every
// emitted window is compared with the 3x3 neighbourhood taken straight from that array.
module tb_conv_window_gen;

    localparam int PW = 8;
    localparam int DW = 10;
    localparam int HW = 10;

    logic           i_clk = 1'b0;
    logic           i_reset_n = 1'b0;
    logic           i_cfg_valid = 1'b0;
    logic [DW-1:0]  i_img_width = '0;
    logic [HW-1:0]  i_img_height = '0;
    logic           o_cfg_err, o_busy, o_lb_load_depth;
    logic [DW-1:0]  o_lb_depth;
    logic           i_col_valid = 1'b0;
    logic [PW-1:0]  i_col_top = '0, i_col_mid = '0, i_col_bot = '0;
    logic           o_win_valid;
    logic [9*PW-1:0] o_win;
    logic [8:0]     o_win_row, o_win_col;
    logic           o_frame_done;

    conv_window_gen #(.WIDTH(PW), .MAX_WIDTH(512), .MAX_HEIGHT(512)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n),
        .i_cfg_valid(i_cfg_valid), .i_img_width(i_img_width), .i_img_height(i_img_height),
        .o_cfg_err(o_cfg_err), .o_busy(o_busy),
        .o_lb_load_depth(o_lb_load_depth), .o_lb_depth(o_lb_depth),
        .i_col_valid(i_col_valid), .i_col_top(i_col_top), .i_col_mid(i_col_mid), .i_col_bot(i_col_bot),
        .o_win_valid(o_win_valid), .o_win(o_win), .o_win_row(o_win_row), .o_win_col(o_win_col),
        .o_frame_done(o_frame_done)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail = 0;
    int win_cnt, done_cnt;
    bit last_was_win;
    logic [9*PW-1:0] last_win, first_win;
    logic [PW-1:0] pix [0:15][0:15];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] px(input int r, input int c);
        if (r < 0) return '0;
        return pix[r][c];
    endfunction

    function automatic logic [9*PW-1:0] model_win(input int r, input int c);
        logic [9*PW-1:0] w;
        w = '0;
        for (int rr = 0; rr < 3; rr++)
            for (int cc = 0; cc < 3; cc++)
                w[(rr*3+cc)*PW +: PW] = pix[r-2+rr][c-2+cc];
        return w;
    endfunction

    task automatic send_beat(input int r, input int c, input int w, input int h);
        logic exp_v, exp_d;
        i_col_valid = 1'b1;
        i_col_top = px(r-2, c);
        i_col_mid = px(r-1, c);
        i_col_bot = px(r, c);
        @(posedge i_clk); #1;
        i_col_valid = 1'b0;
        exp_v = (r >= 2) && (c >= 2);
        exp_d = (r == h-1) && (c == w-1);
        chk("win_valid", 128'(o_win_valid), 128'(exp_v));
        chk("frame_done", 128'(o_frame_done), 128'(exp_d));
        chk("load_quiet", 128'(o_lb_load_depth), 128'(0));
        if (exp_v) begin
            chk("win_row", 128'(o_win_row), 128'(r));
            chk("win_col", 128'(o_win_col), 128'(c));
            chk("win_data", 128'(o_win), 128'(model_win(r, c)));
            if (win_cnt == 0) first_win = o_win;
            last_win = model_win(r, c);
        end
        if (o_win_valid) win_cnt++;
        if (o_frame_done) done_cnt++;
        last_was_win = exp_v;
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            i_col_valid = 1'b0;
            i_col_top = PW'($urandom);
            i_col_mid = PW'($urandom);
            i_col_bot = PW'($urandom);
            @(posedge i_clk); #1;
            chk("gap_valid", 128'(o_win_valid), 128'(0));
            chk("gap_done", 128'(o_frame_done), 128'(0));
            if (last_was_win) chk("gap_hold", 128'(o_win), 128'(last_win));
        end
    endtask

    task automatic do_cfg(input int w, input int h, input bit with_beat);
        bit ok;
        ok = (w >= 3) && (w <= 512) && (h >= 3) && (h <= 512);
        i_cfg_valid = 1'b1;
        i_img_width = DW'(w);
        i_img_height = HW'(h);
        i_col_valid = with_beat;
        i_col_top = PW'($urandom);
        i_col_mid = PW'($urandom);
        i_col_bot = PW'($urandom);
        @(posedge i_clk); #1;
        i_cfg_valid = 1'b0;
        i_col_valid = 1'b0;
        chk("cfg_err", 128'(o_cfg_err), 128'(!ok));
        chk("cfg_win_valid", 128'(o_win_valid), 128'(0));
        chk("cfg_frame_done", 128'(o_frame_done), 128'(0));
        if (ok) begin
            chk("load_pulse", 128'(o_lb_load_depth), 128'(1));
            chk("load_depth", 128'(o_lb_depth), 128'(w));
            chk("load_busy", 128'(o_busy), 128'(1));
            @(posedge i_clk); #1;
            chk("load_end", 128'(o_lb_load_depth), 128'(0));
            chk("run_busy", 128'(o_busy), 128'(1));
            chk("depth_hold", 128'(o_lb_depth), 128'(w));
        end else begin
            chk("no_load", 128'(o_lb_load_depth), 128'(0));
            chk("err_idle", 128'(o_busy), 128'(0));
        end
        last_was_win = 1'b0;
    endtask

    task automatic run_frame(input int w, input int h, input bit pattern, input int gap_pct,
                             input int gap_r, input int gap_c, input int stop_after);
        int n;
        n = 0;
        win_cnt = 0;
        done_cnt = 0;
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++)
                pix[r][c] = pattern ? PW'(r*16 + c) : PW'($urandom);
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                if (stop_after >= 0 && n == stop_after) begin
                    chk("abort_no_done", 128'(done_cnt), 128'(0));
                    return;
                end
                if (r == gap_r && c == gap_c) gap(3);
                else if (gap_pct > 0 && $urandom_range(99) < gap_pct) gap($urandom_range(1, 3));
                send_beat(r, c, w, h);
                n++;
            end
        end
        chk("win_count", 128'(win_cnt), 128'((w-2)*(h-2)));
        chk("done_count", 128'(done_cnt), 128'(1));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 128'(o_busy), 128'(0));
        chk({tag, "_err"}, 128'(o_cfg_err), 128'(0));
        chk({tag, "_load"}, 128'(o_lb_load_depth), 128'(0));
        chk({tag, "_depth"}, 128'(o_lb_depth), 128'(0));
        chk({tag, "_valid"}, 128'(o_win_valid), 128'(0));
        chk({tag, "_win"}, 128'(o_win), 128'(0));
        chk({tag, "_row"}, 128'(o_win_row), 128'(0));
        chk({tag, "_col"}, 128'(o_win_col), 128'(0));
        chk({tag, "_done"}, 128'(o_frame_done), 128'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #22;
        chk_all_zero("reset");
        #5 i_reset_n = 1'b1;
        @(posedge i_clk); #1;

        // Small pattern frame with known corner values.
        do_cfg(4, 3, 1'b0);
        run_frame(4, 3, 1'b1, 0, -1, -1, -1);
        chk("first_win_00", 128'(first_win[0 +: PW]), 128'(8'h00));
        chk("first_win_22", 128'(first_win[8*PW +: PW]), 128'(8'h22));

        // Too-narrow config goes to IDLE; minimum legal size yields a single window.
        do_cfg(2, 5, 1'b0);
        do_cfg(3, 3, 1'b0);
        run_frame(3, 3, 1'b0, 0, -1, -1, -1);

        // Three idle cycles mid row 2, right after a window beat.
        do_cfg(5, 4, 1'b0);
        run_frame(5, 4, 1'b0, 0, 2, 3, -1);

        // Back-to-back frames without reconfiguration.
        do_cfg(4, 4, 1'b0);
        run_frame(4, 4, 1'b0, 0, -1, -1, -1);
        run_frame(4, 4, 1'b0, 0, -1, -1, -1);

        // Reconfigure mid-frame at row 1; the coincident beat is dropped.
        do_cfg(4, 4, 1'b0);
        run_frame(4, 4, 1'b0, 0, -1, -1, 5);
        do_cfg(6, 3, 1'b1);
        run_frame(6, 3, 1'b0, 0, -1, -1, -1);

        // Out-of-range configs, including one issued while running.
        do_cfg(600, 5, 1'b1);
        do_cfg(5, 1, 1'b0);
        do_cfg(5, 513, 1'b0);

        repeat (3) begin
            int w, h;
            w = $urandom_range(3, 10);
            h = $urandom_range(3, 8);
            do_cfg(w, h, 1'b0);
            run_frame(w, h, 1'b0, 25, -1, -1, -1);
        end

        // Asynchronous reset right after a window beat.
        do_cfg(6, 5, 1'b0);
        run_frame(6, 5, 1'b0, 0, -1, -1, 15);
        chk("pre_reset_valid", 128'(o_win_valid), 128'(1));
        #2 i_reset_n = 1'b0;
        #1 chk_all_zero("async_rst");
        #10 i_reset_n = 1'b1;
        @(posedge i_clk); #1;
        repeat (4) begin
            i_col_valid = 1'b1;
            i_col_top = PW'($urandom);
            i_col_mid = PW'($urandom);
            i_col_bot = PW'($urandom);
            @(posedge i_clk); #1;
            chk("idle_ignore_valid", 128'(o_win_valid), 128'(0));
            chk("idle_ignore_busy", 128'(o_busy), 128'(0));
        end
        i_col_valid = 1'b0;
        do_cfg(4, 3, 1'b0);
        run_frame(4, 3, 1'b0, 10, -1, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
